// File: rtl/cpu_pkg.sv
// Shared types and constants for the ARM core's fetch stage.
package cpu_pkg;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_WAIT = 2'd1,
    F_HOLD = 2'd2
  } fetch_state_t;

  // MOV R0,R0 - issued to the datapath whenever no valid instruction matches PCF.
  localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

endpackage

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset to zero.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage instruction-memory controller: one outstanding req/gnt/rvalid
// transaction, same-cycle bypass of read data, and a one-entry hold buffer.
//
// Bus handshake: imem_req is asserted only in F_REQ and imem_addr holds
// {PCF[31:2],2'b00}; a transfer is accepted in the cycle imem_req & imem_gnt.
// Exactly one imem_rvalid is expected per accepted request, at least one
// cycle later; imem_rvalid seen outside F_WAIT is ignored.
module imem_fetch_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        StallF,
  input  logic        RedirectF,
  output logic [31:0] InstrF,
  output logic        FetchStallF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  fetch_state_t state_q, state_d;
  logic         drop_q, drop_d;
  logic         buf_valid_q, buf_valid_d;
  logic         tag_en, buf_en;
  logic [29:0]  tag_q;
  logic [31:0]  buf_q;
  logic         tag_match;
  logic         hold_hit;

  // Masking (rather than slicing) keeps every PCF bit referenced.
  assign imem_addr = PCF & 32'hFFFF_FFFC;
  assign tag_match = (tag_q == PCF[31:2]);
  assign hold_hit  = buf_valid_q & tag_match & ~RedirectF;

  flopenr #(.WIDTH(30)) u_tag_reg (
    .clk   (clk),
    .reset (reset),
    .en    (tag_en),
    .d     (PCF[31:2]),
    .q     (tag_q)
  );

  flopenr #(.WIDTH(32)) u_buf_reg (
    .clk   (clk),
    .reset (reset),
    .en    (buf_en),
    .d     (imem_rdata),
    .q     (buf_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= F_REQ;
      drop_q      <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    buf_valid_d = buf_valid_q;
    tag_en      = 1'b0;
    buf_en      = 1'b0;
    imem_req    = 1'b0;
    InstrF      = NOP_INSTR;
    FetchStallF = 1'b1;

    if (!reset) begin
      unique case (state_q)
        F_REQ: begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            tag_en  = 1'b1;
            drop_d  = RedirectF;
            state_d = F_WAIT;
          end
        end

        F_WAIT: begin
          if (RedirectF) drop_d = 1'b1;
          if (imem_rvalid) begin
            // A redirect in the rvalid cycle also makes this response stale.
            if (drop_q || RedirectF || !tag_match) begin
              state_d = F_REQ;
            end else begin
              InstrF      = imem_rdata;
              FetchStallF = 1'b0;
              if (StallF) begin
                buf_en      = 1'b1;
                buf_valid_d = 1'b1;
                state_d     = F_HOLD;
              end else begin
                state_d = F_REQ;
              end
            end
          end
        end

        F_HOLD: begin
          if (hold_hit) begin
            InstrF      = buf_q;
            FetchStallF = 1'b0;
          end
          if (!(hold_hit && StallF)) begin
            buf_valid_d = 1'b0;
            state_d     = F_REQ;
          end
        end

        default: state_d = F_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: memory responses are scripted cycle by cycle.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk;
  logic        reset;
  logic [31:0] PCF;
  logic        StallF;
  logic        RedirectF;
  logic [31:0] InstrF;
  logic        FetchStallF;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  imem_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .PCF         (PCF),
    .StallF      (StallF),
    .RedirectF   (RedirectF),
    .InstrF      (InstrF),
    .FetchStallF (FetchStallF),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checking
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic req, input logic stall,
                           input logic [31:0] instr);
    check_eq({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
    check_eq({tag, ".stall"}, {31'd0, FetchStallF}, {31'd0, stall});
    check_eq({tag, ".instr"}, InstrF,               instr);
  endtask

  // Driver: inputs change on the falling edge, outputs sampled 1ns later.
  task automatic cyc(input logic [31:0] pcf, input logic stall, input logic redir,
                     input logic gnt, input logic rv, input logic [31:0] rdata);
    @(negedge clk);
    PCF         = pcf;
    StallF      = stall;
    RedirectF   = redir;
    imem_gnt    = gnt;
    imem_rvalid = rv;
    imem_rdata  = rdata;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    PCF = '0; StallF = 0; RedirectF = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;

    // Reset state
    cyc(32'h0, 0, 0, 1, 0, 32'h0);
    check_out("rst", 0, 1, NOP);
    cyc(32'h0, 0, 0, 0, 0, 32'h0);
    reset = 1'b0;

    // T1: gnt in cycle 1, rvalid in cycle 2, consumed immediately
    cyc(32'h0, 0, 0, 1, 0, 32'h0);
    check_out("t1.c1", 1, 1, NOP);
    check_eq("t1.addr", imem_addr, 32'h0);
    exp_q.push_back(32'hE3A01005);
    cyc(32'h0, 0, 0, 0, 1, 32'hE3A01005);
    check_out("t1.c2", 0, 0, exp_q.pop_front());

    // T2: cycle 3 requests again; response arrives under StallF -> HOLD
    cyc(32'h4, 0, 0, 1, 0, 32'h0);
    check_out("t2.c3", 1, 1, NOP);
    check_eq("t2.addr", imem_addr, 32'h4);
    exp_q.push_back(32'hE3A01005);
    cyc(32'h4, 1, 0, 0, 1, 32'hE3A01005);
    check_out("t2.rv", 0, 0, exp_q[0]);
    for (int i = 0; i < 3; i++) begin
      // rvalid noise while holding must be ignored
      cyc(32'h4, 1, 0, 0, (i == 1), 32'h1111_1111);
      check_out($sformatf("t2.hold%0d", i), 0, 0, exp_q[0]);
    end
    cyc(32'h4, 0, 0, 0, 0, 32'h0);
    check_out("t2.consume", 0, 0, exp_q.pop_front());
    cyc(32'h8, 0, 0, 0, 0, 32'h0);
    check_out("t2.next", 1, 1, NOP);
    check_eq("t2.next_addr", imem_addr, 32'h8);

    // T3: redirect while waiting drops the response
    cyc(32'h10, 0, 0, 1, 0, 32'h0);
    check_eq("t3.addr", imem_addr, 32'h10);
    cyc(32'h10, 0, 1, 0, 0, 32'h0);
    check_out("t3.wait", 0, 1, NOP);
    cyc(32'h40, 0, 0, 0, 1, 32'hDEADBEEF);
    check_out("t3.rv", 0, 1, NOP);
    cyc(32'h40, 0, 0, 0, 0, 32'h0);
    check_out("t3.req", 1, 1, NOP);
    check_eq("t3.addr2", imem_addr, 32'h40);

    // T4: gnt withheld for 5 cycles (the cycle above was the first)
    for (int i = 0; i < 4; i++) begin
      cyc(32'h40, 0, 0, 0, 0, 32'h0);
      check_out($sformatf("t4.nognt%0d", i), 1, 1, NOP);
      check_eq($sformatf("t4.addr%0d", i), imem_addr, 32'h40);
    end
    cyc(32'h40, 0, 0, 1, 0, 32'h0);
    check_out("t4.gnt", 1, 1, NOP);

    // T5: reset while in WAIT, spurious rvalid after release
    cyc(32'h40, 0, 0, 0, 0, 32'h0);
    check_out("t5.wait", 0, 1, NOP);
    reset = 1'b1;
    cyc(32'h40, 0, 0, 0, 0, 32'h0);
    check_out("t5.rst", 0, 1, NOP);
    reset = 1'b0;
    cyc(32'h80, 0, 0, 0, 0, 32'h0);
    check_out("t5.rel", 1, 1, NOP);
    cyc(32'h80, 0, 0, 0, 1, 32'h1234_5678);
    check_out("t5.spur", 1, 1, NOP);
    check_eq("t5.addr", imem_addr, 32'h80);
    cyc(32'h80, 0, 0, 0, 0, 32'h0);
    check_out("t5.still_req", 1, 1, NOP);

    // T6: buffered 0x20, PCF moves to 0x24 without redirect
    cyc(32'h20, 0, 0, 1, 0, 32'h0);
    check_eq("t6.addr", imem_addr, 32'h20);
    cyc(32'h20, 1, 0, 0, 1, 32'hE2811001);
    check_out("t6.rv", 0, 0, 32'hE2811001);
    cyc(32'h24, 1, 0, 0, 0, 32'h0);
    check_out("t6.mismatch", 0, 1, NOP);
    cyc(32'h27, 0, 0, 0, 0, 32'h0);
    check_out("t6.req", 1, 1, NOP);
    check_eq("t6.addr2", imem_addr, 32'h24);
    cyc(32'h24, 0, 0, 1, 0, 32'h0);
    check_out("t6.gnt", 1, 1, NOP);
    cyc(32'h24, 0, 0, 0, 0, 32'h0);
    check_out("t6.wait", 0, 1, NOP);
    cyc(32'h26, 0, 0, 0, 1, 32'hE0822003);
    check_out("t6.rv2", 0, 0, 32'hE0822003);

    // T7: redirect in HOLD overrides StallF
    cyc(32'h30, 0, 0, 1, 0, 32'h0);
    cyc(32'h30, 1, 0, 0, 1, 32'hE1500001);
    check_out("t7.rv", 0, 0, 32'hE1500001);
    cyc(32'h30, 1, 1, 0, 0, 32'h0);
    check_out("t7.redir", 0, 1, NOP);
    cyc(32'h30, 1, 0, 0, 0, 32'h0);
    check_out("t7.req", 1, 1, NOP);

    // T8: redirect coincident with gnt, then with a matching rvalid
    cyc(32'h30, 0, 1, 1, 0, 32'h0);
    cyc(32'h30, 0, 0, 0, 1, 32'hAAAA_0001);
    check_out("t8.gnt_redir", 0, 1, NOP);
    cyc(32'h30, 0, 0, 1, 0, 32'h0);
    cyc(32'h30, 0, 1, 0, 1, 32'hAAAA_0002);
    check_out("t8.rv_redir", 0, 1, NOP);
    cyc(32'h30, 0, 0, 0, 0, 32'h0);
    check_out("t8.req", 1, 1, NOP);

    check_eq("sb.empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
